ram_bus_arbiter: RTL and testbench

- Shares the single system RAM port between the 6502 core and a video fetch requester, C64 BA/AEC style.
- On a video request, the arbiter drops CPU RDY at once. It then gives the CPU a fixed grace period so in-flight write cycles can finish, and only then hands the RAM port to video.
- Sits between the 6502 core, the video fetch unit and the RAM array. RAM reads are combinational: data is valid in the same cycle as the address.

---
 rtl/ram_bus_arbiter.sv | 118 +++++++++++
 tb/tb_ram_bus_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bus_arbiter.sv
// ============================================================================
// Module   : ram_bus_arbiter
// Purpose  : Shares one RAM port between the 6502 core and video fetch,
//            C64 BA/AEC style: RDY drops first, video is granted later.
// Revision : 1.0
// ============================================================================
`default_nettype none

module ram_bus_arbiter #(
  parameter int STEAL_DELAY = 3,
  parameter int AW          = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] cpu_ab,
  input  logic [7:0]    cpu_do,
  input  logic          cpu_we,
  output logic [7:0]    cpu_di,
  output logic          cpu_rdy,
  input  logic          vid_req,
  input  logic [AW-1:0] vid_addr,
  output logic          vid_grant,
  output logic [7:0]    vid_data,
  output logic [AW-1:0] ram_ab,
  output logic [7:0]    ram_do,
  output logic          ram_we,
  input  logic [7:0]    ram_di,
  output logic          proto_err,
  output logic [15:0]   steal_cnt
);

  typedef enum logic [1:0] {
    S_CPU  = 2'd0,
    S_WARN = 2'd1,
    S_VID  = 2'd2
  } state_t;

  // The counter holds STEAL_DELAY-1 on WARN entry; WARN then lasts STEAL_DELAY cycles.
  localparam logic [3:0] c_warn_load = (STEAL_DELAY > 0) ? 4'(STEAL_DELAY - 1) : 4'd0;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        grant_q;
  logic        proto_q;
  logic [15:0] steal_q;
  logic        w_vid_own;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_CPU: begin
        if (vid_req) begin
          if (STEAL_DELAY == 0) begin
            state_d = S_VID;
          end else begin
            state_d = S_WARN;
            cnt_d   = c_warn_load;
          end
        end
      end
      S_WARN: begin
        if (!vid_req) begin
          state_d = S_CPU;
        end else if (cnt_q == 4'd0) begin
          state_d = S_VID;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_VID: begin
        if (!vid_req) begin
          state_d = S_CPU;
        end
      end
      default: state_d = S_CPU;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_CPU;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b1;
      grant_q <= 1'b0;
      proto_q <= 1'b0;
      steal_q <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d == S_CPU);
      grant_q <= (state_d == S_VID);
      if ((state_q == S_VID) && cpu_we) begin
        proto_q <= 1'b1;
      end
      if ((state_q == S_VID) && (steal_q != 16'hFFFF)) begin
        steal_q <= steal_q + 16'd1;
      end
    end
  end

  // CPU writes attempted while video owns the port are dropped here.
  assign w_vid_own = (state_q == S_VID);
  assign ram_ab    = w_vid_own ? vid_addr : cpu_ab;
  assign ram_we    = w_vid_own ? 1'b0 : cpu_we;
  assign ram_do    = cpu_do;
  assign cpu_di    = w_vid_own ? 8'hFF : ram_di;
  assign vid_data  = w_vid_own ? ram_di : 8'h00;

  assign cpu_rdy   = rdy_q;
  assign vid_grant = grant_q;
  assign proto_err = proto_q;
  assign steal_cnt = steal_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_arbiter.sv
// ============================================================================
// Module   : tb_ram_bus_arbiter
// Purpose  : Scoreboard bench for ram_bus_arbiter (STEAL_DELAY 3 and 0).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ram_bus_arbiter;

  localparam int SEL_RDY    = 0;
  localparam int SEL_GRANT  = 1;
  localparam int SEL_CPUDI  = 2;
  localparam int SEL_RAMWE  = 3;
  localparam int SEL_VDATA  = 4;
  localparam int SEL_PROTO  = 5;
  localparam int SEL_STEAL  = 6;
  localparam int SEL_RAMAB  = 7;
  localparam int SEL_MEM    = 8;
  localparam int SEL_GRANT0 = 9;
  localparam int SEL_RDY0   = 10;
  localparam int SEL_VDATA0 = 11;
  localparam int SEL_STEAL0 = 12;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] cpu_ab;
  logic [7:0]  cpu_do;
  logic        cpu_we;
  logic [7:0]  cpu_di;
  logic        cpu_rdy;
  logic        vid_req;
  logic [15:0] vid_addr;
  logic        vid_grant;
  logic [7:0]  vid_data;
  logic [15:0] ram_ab;
  logic [7:0]  ram_do;
  logic        ram_we;
  logic [7:0]  ram_di;
  logic        proto_err;
  logic [15:0] steal_cnt;

  logic        vid_req0;
  logic [7:0]  cpu_di0;
  logic        cpu_rdy0;
  logic        vid_grant0;
  logic [7:0]  vid_data0;
  logic [15:0] ram_ab0;
  logic [7:0]  ram_do0;
  logic        ram_we0;
  logic [7:0]  ram_di0;
  logic        proto_err0;
  logic [15:0] steal_cnt0;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    logic [15:0] addr;
    string       name;
  } exp_t;

  exp_t exq[$];

  always #5 clk = ~clk;

  ram_bus_arbiter #(.STEAL_DELAY(3), .AW(16)) dut (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di), .cpu_rdy(cpu_rdy),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_grant(vid_grant), .vid_data(vid_data),
    .ram_ab(ram_ab), .ram_do(ram_do), .ram_we(ram_we), .ram_di(ram_di),
    .proto_err(proto_err), .steal_cnt(steal_cnt)
  );

  ram_bus_arbiter #(.STEAL_DELAY(0), .AW(16)) dut0 (
    .clk(clk), .reset(reset),
    .cpu_ab(cpu_ab), .cpu_do(cpu_do), .cpu_we(cpu_we), .cpu_di(cpu_di0), .cpu_rdy(cpu_rdy0),
    .vid_req(vid_req0), .vid_addr(vid_addr), .vid_grant(vid_grant0), .vid_data(vid_data0),
    .ram_ab(ram_ab0), .ram_do(ram_do0), .ram_we(ram_we0), .ram_di(ram_di0),
    .proto_err(proto_err0), .steal_cnt(steal_cnt0)
  );

  // Main RAM: combinational read, write on the rising edge.
  assign ram_di  = mem[ram_ab];
  assign ram_di0 = ram_ab0[7:0] ^ 8'hA5;

  always @(posedge clk) begin
    if (ram_we) mem[ram_ab] <= ram_do;
    cyc <= cyc + 1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input int c, input int sel, input logic [31:0] exp,
                           input string name, input logic [15:0] addr = 16'h0000);
    exp_t e;
    e.cyc = c; e.sel = sel; e.exp = exp; e.addr = addr; e.name = name;
    exq.push_back(e);
  endtask

  function automatic logic [31:0] actual(input int sel, input logic [15:0] addr);
    case (sel)
      SEL_RDY:    actual = {31'd0, cpu_rdy};
      SEL_GRANT:  actual = {31'd0, vid_grant};
      SEL_CPUDI:  actual = {24'd0, cpu_di};
      SEL_RAMWE:  actual = {31'd0, ram_we};
      SEL_VDATA:  actual = {24'd0, vid_data};
      SEL_PROTO:  actual = {31'd0, proto_err};
      SEL_STEAL:  actual = {16'd0, steal_cnt};
      SEL_RAMAB:  actual = {16'd0, ram_ab};
      SEL_MEM:    actual = {24'd0, mem[addr]};
      SEL_GRANT0: actual = {31'd0, vid_grant0};
      SEL_RDY0:   actual = {31'd0, cpu_rdy0};
      SEL_VDATA0: actual = {24'd0, vid_data0};
      SEL_STEAL0: actual = {16'd0, steal_cnt0};
      default:    actual = 32'hDEAD_BEEF;
    endcase
  endfunction

  // Monitor: mid-cycle, retire every expectation scheduled for this cycle.
  always @(negedge clk) begin
    for (int i = exq.size() - 1; i >= 0; i--) begin
      if (exq[i].cyc == cyc) begin
        cmp(exq[i].name, actual(exq[i].sel, exq[i].addr), exq[i].exp);
        exq.delete(i);
      end else if (exq[i].cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for cycle %0d never sampled", exq[i].name, exq[i].cyc);
        exq.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    reset = 1'b1; vid_req = 1'b0; vid_req0 = 1'b0;
    cpu_we = 1'b0; cpu_ab = 16'h0000; cpu_do = 8'h00; vid_addr = 16'h0016;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0016] = 8'h21;
    mem[16'h0030] = 8'h5C;

    tick(); tick();
    cmp("reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    cmp("reset_grant", {31'd0, vid_grant}, 32'd0);
    cmp("reset_proto", {31'd0, proto_err}, 32'd0);
    cmp("reset_steal", {16'd0, steal_cnt}, 32'd0);
    cmp("reset_grant0", {31'd0, vid_grant0}, 32'd0);
    #2 reset = 1'b0;
    tick();

    // Idle CPU write then read back.
    c = cyc;
    cpu_ab = 16'h0011; cpu_do = 8'h27; cpu_we = 1'b1;
    expect_at(c, SEL_RAMWE, 1, "idle_write_we");
    expect_at(c, SEL_RDY, 1, "idle_write_rdy");
    expect_at(c, SEL_RAMAB, 16'h0011, "idle_write_ab");
    tick();
    cpu_we = 1'b0;
    expect_at(c + 1, SEL_CPUDI, 8'h27, "idle_read_di");
    expect_at(c + 1, SEL_RDY, 1, "idle_read_rdy");
    expect_at(c + 1, SEL_STEAL, 0, "idle_steal");
    expect_at(c + 1, SEL_RAMWE, 0, "idle_read_we");
    tick();

    // Steal, STEAL_DELAY=3, with a CPU write in the second WARN cycle.
    c = cyc;
    vid_req = 1'b1; vid_addr = 16'h0016;
    expect_at(c + 1, SEL_RDY, 0, "steal_rdy_low");
    expect_at(c + 1, SEL_GRANT, 0, "steal_warn_grant1");
    expect_at(c + 2, SEL_RAMWE, 1, "warn_write_we");
    expect_at(c + 3, SEL_GRANT, 0, "steal_warn_grant3");
    expect_at(c + 3, SEL_MEM, 8'h47, "warn_write_mem", 16'h0017);
    expect_at(c + 3, SEL_PROTO, 0, "warn_write_proto");
    expect_at(c + 4, SEL_GRANT, 1, "steal_grant");
    expect_at(c + 4, SEL_VDATA, 8'h21, "steal_vdata");
    expect_at(c + 4, SEL_RAMAB, 16'h0016, "steal_ramab");
    expect_at(c + 4, SEL_CPUDI, 8'hFF, "steal_cpudi");
    expect_at(c + 5, SEL_GRANT, 1, "steal_grant2");
    expect_at(c + 5, SEL_RAMWE, 0, "steal_ramwe");
    expect_at(c + 6, SEL_GRANT, 0, "release_grant");
    expect_at(c + 6, SEL_RDY, 1, "release_rdy");
    expect_at(c + 6, SEL_STEAL, 2, "release_steal");
    expect_at(c + 6, SEL_VDATA, 8'h00, "release_vdata");
    tick();
    tick();
    cpu_ab = 16'h0017; cpu_do = 8'h47; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0;
    tick();
    tick();
    vid_req = 1'b0;
    tick();
    tick();

    // Abort: request seen in CPU and once in WARN, then withdrawn.
    c = cyc;
    vid_req = 1'b1;
    expect_at(c, SEL_RDY, 1, "abort_pre_rdy");
    expect_at(c + 1, SEL_RDY, 0, "abort_rdy_low1");
    expect_at(c + 2, SEL_RDY, 0, "abort_rdy_low2");
    expect_at(c + 2, SEL_GRANT, 0, "abort_grant2");
    expect_at(c + 3, SEL_RDY, 1, "abort_rdy_back");
    expect_at(c + 3, SEL_GRANT, 0, "abort_grant3");
    expect_at(c + 3, SEL_STEAL, 2, "abort_steal");
    tick();
    tick();
    vid_req = 1'b0;
    tick();
    tick();

    // Illegal CPU write while video owns the port.
    c = cyc;
    vid_req = 1'b1; vid_addr = 16'h0016;
    expect_at(c + 4, SEL_GRANT, 1, "illegal_grant");
    expect_at(c + 4, SEL_RAMWE, 0, "illegal_ramwe");
    expect_at(c + 4, SEL_RAMAB, 16'h0016, "illegal_ramab");
    expect_at(c + 4, SEL_PROTO, 0, "illegal_proto_before");
    expect_at(c + 5, SEL_PROTO, 1, "illegal_proto_set");
    expect_at(c + 6, SEL_GRANT, 0, "illegal_release");
    expect_at(c + 6, SEL_STEAL, 4, "illegal_steal");
    expect_at(c + 6, SEL_MEM, 8'h5C, "illegal_mem_kept", 16'h0030);
    expect_at(c + 7, SEL_PROTO, 1, "illegal_proto_sticky");
    for (int k = 0; k < 4; k++) tick();
    cpu_ab = 16'h0030; cpu_do = 8'h99; cpu_we = 1'b1;
    tick();
    cpu_we = 1'b0; vid_req = 1'b0;
    tick(); tick(); tick();

    // Reset mid-burst: outputs must clear without a clock edge.
    c = cyc;
    vid_req = 1'b1;
    expect_at(c + 4, SEL_GRANT, 1, "rst_burst_grant");
    for (int k = 0; k < 5; k++) tick();
    #2 reset = 1'b1;
    #1;
    cmp("async_rst_grant", {31'd0, vid_grant}, 32'd0);
    cmp("async_rst_rdy", {31'd0, cpu_rdy}, 32'd1);
    cmp("async_rst_steal", {16'd0, steal_cnt}, 32'd0);
    cmp("async_rst_proto", {31'd0, proto_err}, 32'd0);
    cmp("async_rst_ramab", {16'd0, ram_ab}, {16'd0, cpu_ab});
    vid_req = 1'b0;
    tick();
    reset = 1'b0;
    c = cyc;
    expect_at(c + 1, SEL_GRANT, 0, "post_rst_grant");
    expect_at(c + 1, SEL_RDY, 1, "post_rst_rdy");
    expect_at(c + 1, SEL_STEAL, 0, "post_rst_steal");
    tick(); tick();

    // STEAL_DELAY=0 instance: grant one edge after the request.
    c = cyc;
    vid_req0 = 1'b1; vid_addr = 16'h0042;
    expect_at(c, SEL_GRANT0, 0, "d0_grant_pre");
    expect_at(c + 1, SEL_GRANT0, 1, "d0_grant");
    expect_at(c + 1, SEL_RDY0, 0, "d0_rdy_low");
    expect_at(c + 1, SEL_VDATA0, 8'hE7, "d0_vdata");
    expect_at(c + 2, SEL_GRANT0, 0, "d0_release");
    expect_at(c + 2, SEL_RDY0, 1, "d0_rdy_back");
    expect_at(c + 2, SEL_STEAL0, 1, "d0_steal");
    tick();
    vid_req0 = 1'b0;
    tick(); tick(); tick();

    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", exq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
